// File: rtl/matrix_loader_tx.sv
// rtl/matrix_loader_tx.sv - transmit end of the matrix-loader serial protocol
// Emits one job frame: 4 dimension cycles, N element cycles, 2 separator cycles.
module matrix_loader_tx #(
  parameter int DATA_W   = 8,
  parameter int MAX_DIM  = 4,
  parameter int MAX_ELEM = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] c2,
  output logic [DATA_W-1:0] data_send,
  output logic [1:0]        ctrl_logic,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX_DIM_V  = DATA_W'(MAX_DIM);
  localparam logic [PW-1:0]     MAX_ELEM_V = PW'(MAX_ELEM);

  typedef enum logic [1:0] {S_IDLE, S_DIMS, S_DATA, S_SEP} state_t;

  logic [DATA_W-1:0] mem [MAX_ELEM];

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [ADDR_W-1:0] n_last, n_last_n;
  logic [DATA_W-1:0] c1_q, r2_q, c2_q, c1_n, r2_n, c2_n;
  logic [DATA_W-1:0] data_n;
  logic [1:0]        ctrl_n;
  logic              busy_n, done_n, err_n;
  logic [PW-1:0]     prod1, prod2, n_sum;
  logic              dims_ok, start_ok;

  // Element buffer: writable only between frames so a frame sees stable contents.
  always_ff @(posedge CLK) begin
    if (wr_en && !busy)
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    prod1    = PW'(r1) * PW'(c1);
    prod2    = PW'(r2) * PW'(c2);
    n_sum    = prod1 + prod2;
    dims_ok  = (r1 != '0) && (r1 <= MAX_DIM_V) && (c1 != '0) && (c1 <= MAX_DIM_V) &&
               (r2 != '0) && (r2 <= MAX_DIM_V) && (c2 != '0) && (c2 <= MAX_DIM_V);
    start_ok = dims_ok && (c1 == r2) && (n_sum <= MAX_ELEM_V);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rd_addr_n = rd_addr;
    n_last_n  = n_last;
    c1_n      = c1_q;
    r2_n      = r2_q;
    c2_n      = c2_q;
    data_n    = data_send;
    ctrl_n    = ctrl_logic;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_n  = S_DIMS;
            cnt_n    = 2'd1;
            c1_n     = c1;
            r2_n     = r2;
            c2_n     = c2;
            n_last_n = ADDR_W'(n_sum - PW'(1));
            data_n   = r1;
            ctrl_n   = 2'd1;
            busy_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DIMS: begin
        cnt_n = cnt + 2'd1;
        case (cnt)
          2'd1:    data_n = c1_q;
          2'd2:    data_n = r2_q;
          default: begin
            data_n    = c2_q;
            rd_addr_n = '0;
            state_n   = S_DATA;
          end
        endcase
      end
      S_DATA: begin
        // rd_addr is already pointing at the next element, so no bubble on the bus.
        data_n    = mem[rd_addr];
        ctrl_n    = 2'd0;
        rd_addr_n = rd_addr + ADDR_W'(1);
        if (rd_addr == n_last) begin
          state_n = S_SEP;
          cnt_n   = 2'd0;
        end
      end
      default: begin
        // Third step drops busy without sampling start, so a start during done is missed.
        data_n = '0;
        ctrl_n = 2'd2;
        cnt_n  = cnt + 2'd1;
        if (cnt == 2'd1)
          done_n = 1'b1;
        if (cnt == 2'd2) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rd_addr    <= '0;
      n_last     <= '0;
      c1_q       <= '0;
      r2_q       <= '0;
      c2_q       <= '0;
      data_send  <= '0;
      ctrl_logic <= 2'd2;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rd_addr    <= rd_addr_n;
      n_last     <= n_last_n;
      c1_q       <= c1_n;
      r2_q       <= r2_n;
      c2_q       <= c2_n;
      data_send  <= data_n;
      ctrl_logic <= ctrl_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_matrix_loader_tx.sv
// tb/tb_matrix_loader_tx.sv - directed bench for matrix_loader_tx
// Table of jobs plus hand sequences for interlock, back-to-back and async reset.
module tb_matrix_loader_tx;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int MAX_ELEM = 32;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] r1 = '0, c1 = '0, r2 = '0, c2 = '0;
  logic [DATA_W-1:0] data_send;
  logic [1:0]        ctrl_logic;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [MAX_ELEM];

  typedef struct {
    int r1;
    int c1;
    int r2;
    int c2;
    bit ok;
  } vec_t;

  vec_t vecs [9];

  matrix_loader_tx #(.DATA_W(DATA_W), .MAX_DIM(4), .MAX_ELEM(MAX_ELEM), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .r1(r1), .c1(c1), .r2(r2), .c2(c2), .data_send(data_send),
    .ctrl_logic(ctrl_logic), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic write_buf(input int addr, input int val);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = val[7:0];
    tick();
    wr_en = 1'b0;
    model[addr] = val[7:0];
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ctrl"}, 32'(ctrl_logic), 2);
    chk({name, "_data"}, 32'(data_send), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
  endtask

  task automatic run_job(input int a, input int b, input int c, input int d,
                         input bit ok, input int poke_k, input bit b2b);
    int n;
    logic [7:0] dims [4];
    logic [7:0] exp_d;
    logic [1:0] exp_c;
    r1 = a[7:0];
    c1 = b[7:0];
    r2 = c[7:0];
    c2 = d[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!ok) begin
      chk("rej_err", 32'(err), 1);
      chk("rej_busy", 32'(busy), 0);
      chk("rej_ctrl", 32'(ctrl_logic), 2);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("rej_err_clear", 32'(err), 0);
        chk_idle("rej_after");
      end
    end else begin
      n = a * b + c * d;
      dims[0] = a[7:0];
      dims[1] = b[7:0];
      dims[2] = c[7:0];
      dims[3] = d[7:0];
      for (int k = 0; k < n + 6; k++) begin
        if (k < 4) begin
          exp_c = 2'd1;
          exp_d = dims[k];
        end else if (k < 4 + n) begin
          exp_c = 2'd0;
          exp_d = model[k-4];
        end else begin
          exp_c = 2'd2;
          exp_d = 8'd0;
        end
        chk("frame_ctrl", 32'(ctrl_logic), 32'(exp_c));
        chk("frame_data", 32'(data_send), 32'(exp_d));
        chk("frame_busy", 32'(busy), 1);
        chk("frame_done", 32'(done), 32'(k == n + 5));
        chk("frame_err", 32'(err), 0);
        if (k == poke_k) begin
          start   = 1'b1;
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = 8'hFF;
        end
        if (b2b && k == n + 5) begin
          start = 1'b1;
          r1 = 8'd1;
          c1 = 8'd1;
          r2 = 8'd1;
          c2 = 8'd1;
        end
        tick();
        if (k == poke_k) begin
          start = 1'b0;
          wr_en = 1'b0;
        end
      end
      chk_idle("post_frame");
      if (b2b) begin
        tick();
        start = 1'b0;
        chk("b2b_ctrl", 32'(ctrl_logic), 1);
        chk("b2b_data", 32'(data_send), 1);
        repeat (8) tick();
        chk("b2b_end_busy", 32'(busy), 0);
      end
    end
  endtask

  initial begin
    vecs = '{
      '{2, 2, 2, 2, 1'b1},
      '{1, 3, 3, 2, 1'b1},
      '{2, 3, 2, 2, 1'b0},
      '{0, 2, 2, 2, 1'b0},
      '{2, 2, 2, 0, 1'b0},
      '{5, 1, 1, 1, 1'b0},
      '{4, 4, 4, 4, 1'b1},
      '{1, 1, 1, 1, 1'b1},
      '{4, 4, 4, 5, 1'b0}
    };

    repeat (2) @(posedge CLK);
    #1;
    chk_idle("rst_low");
    chk("rst_low_err", 32'(err), 0);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("rst_idle");
      chk("rst_idle_err", 32'(err), 0);
    end

    for (int i = 0; i < MAX_ELEM; i++)
      write_buf(i, 8'h11 + i);

    for (int i = 0; i < 9; i++)
      run_job(vecs[i].r1, vecs[i].c1, vecs[i].r2, vecs[i].c2, vecs[i].ok, -1, 1'b0);

    for (int i = 0; i < 9; i++)
      write_buf(i, i + 1);
    run_job(1, 3, 3, 2, 1'b1, -1, 1'b0);

    // Busy interlock: start and write during DATA must not disturb anything.
    run_job(2, 2, 2, 2, 1'b1, 6, 1'b0);
    run_job(2, 2, 2, 2, 1'b1, -1, 1'b0);

    run_job(2, 2, 2, 2, 1'b1, -1, 1'b1);

    // Async reset at element 3 of a 2x2*2x2 frame.
    r1 = 8'd2;
    c1 = 8'd2;
    r2 = 8'd2;
    c2 = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_reset_elem3", 32'(data_send), 32'(model[3]));
    #3;
    RST_N = 1'b0;
    #1;
    chk_idle("async_rst");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_idle("after_rst");
    end
    run_job(2, 2, 2, 2, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
